// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command sequencer.
// Holds the command byte values and the parser state encoding.
package spi_cmd_pkg;

    localparam logic [7:0] CMD_CONF_WR   = 8'h2A;
    localparam logic [7:0] CMD_ADDR_WR   = 8'h2B;
    localparam logic [7:0] CMD_DATA_WR   = 8'h2C;
    localparam logic [7:0] CMD_FRAME_GO  = 8'h2D;
    localparam logic [7:0] CMD_STATUS_RD = 8'h2E;

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_CONF_H = 3'd1,
        ST_CONF_L = 3'd2,
        ST_ADDR_H = 3'd3,
        ST_ADDR_L = 3'd4,
        ST_DATA   = 3'd5,
        ST_SINK   = 3'd6
    } state_e;

endpackage

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between the SPI byte slave and the LED frame logic.
// Parses each chip-select frame into a command plus arguments and drives
// the pixel RAM write port, the LED-count register and the frame-start
// request; supplies the status reply byte for MISO.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   spi_cs_n_i              chip select (active low)
//   spi_byte_vld_i/data_i   received byte strobe and value
//   spi_byte_data_o         next byte for the slave to transmit
//   frame_busy_i            LED output engine refreshing
//   ram_wr_en/addr/data_o   registered pixel RAM write port
//   led_cnt_o               configured LED count
//   frame_start_o           one-cycle refresh request
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_byte_vld_i,
    input  logic [7:0]            spi_byte_data_i,
    output logic [7:0]            spi_byte_data_o,
    input  logic                  frame_busy_i,
    output logic                  ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [7:0]            ram_wr_data_o,
    output logic [CNT_WIDTH-1:0]  led_cnt_o,
    output logic                  frame_start_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [7:0]            hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  pending_q, pending_d;
    logic [CNT_WIDTH-1:0]  led_cnt_q, led_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  start_q, start_d;
    logic [7:0]            reply_q, reply_d;
    logic [15:0]           arg16;

    // Both two-byte arguments share the high-byte hold register.
    assign arg16 = {hold_q, spi_byte_data_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_CMD;
            hold_q    <= 8'h00;
            addr_q    <= '0;
            pending_q <= 1'b0;
            led_cnt_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            start_q   <= 1'b0;
            reply_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            addr_q    <= addr_d;
            pending_q <= pending_d;
            led_cnt_q <= led_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            reply_q   <= reply_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        addr_d    = addr_q;
        pending_d = pending_q;
        led_cnt_d = led_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;
        reply_d   = reply_q;

        // Start request is independent of the byte stream; a FRAME_GO in the
        // same cycle re-arms pending below.
        if (pending_q && !frame_busy_i) begin
            start_d   = 1'b1;
            pending_d = 1'b0;
        end

        if (spi_cs_n_i) begin
            // Release aborts any partial argument; bytes seen now are dropped.
            state_d = ST_CMD;
            reply_d = 8'h00;
        end else if (spi_byte_vld_i) begin
            reply_d = 8'h00;
            unique case (state_q)
                ST_CMD: begin
                    state_d = ST_SINK;
                    case (spi_byte_data_i)
                        CMD_CONF_WR:   state_d = ST_CONF_H;
                        CMD_ADDR_WR:   state_d = ST_ADDR_H;
                        CMD_DATA_WR:   state_d = ST_DATA;
                        CMD_FRAME_GO:  pending_d = 1'b1;
                        CMD_STATUS_RD: reply_d = {6'h00, pending_q, frame_busy_i};
                        default:       state_d = ST_SINK;
                    endcase
                end
                ST_CONF_H: begin
                    hold_d  = spi_byte_data_i;
                    state_d = ST_CONF_L;
                end
                ST_CONF_L: begin
                    led_cnt_d = arg16[CNT_WIDTH-1:0];
                    state_d   = ST_SINK;
                end
                ST_ADDR_H: begin
                    hold_d  = spi_byte_data_i;
                    state_d = ST_ADDR_L;
                end
                ST_ADDR_L: begin
                    addr_d  = arg16[ADDR_WIDTH-1:0];
                    state_d = ST_SINK;
                end
                ST_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = spi_byte_data_i;
                    addr_d    = addr_q + ADDR_ONE;
                end
                default: state_d = ST_SINK;
            endcase
        end
    end

    assign spi_byte_data_o = reply_q;
    assign ram_wr_en_o     = wr_en_q;
    assign ram_wr_addr_o   = wr_addr_q;
    assign ram_wr_data_o   = wr_data_q;
    assign led_cnt_o       = led_cnt_q;
    assign frame_start_o   = start_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
module tb_spi_cmd_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        spi_cs_n_i;
    logic        spi_byte_vld_i;
    logic [7:0]  spi_byte_data_i;
    logic [7:0]  spi_byte_data_o;
    logic        frame_busy_i;
    logic        ram_wr_en_o;
    logic [10:0] ram_wr_addr_o;
    logic [7:0]  ram_wr_data_o;
    logic [15:0] led_cnt_o;
    logic        frame_start_o;

    int checks = 0;
    int errors = 0;

    spi_cmd_ctrl #(.ADDR_WIDTH(11), .CNT_WIDTH(16)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .spi_cs_n_i      (spi_cs_n_i),
        .spi_byte_vld_i  (spi_byte_vld_i),
        .spi_byte_data_i (spi_byte_data_i),
        .spi_byte_data_o (spi_byte_data_o),
        .frame_busy_i    (frame_busy_i),
        .ram_wr_en_o     (ram_wr_en_o),
        .ram_wr_addr_o   (ram_wr_addr_o),
        .ram_wr_data_o   (ram_wr_data_o),
        .led_cnt_o       (led_cnt_o),
        .frame_start_o   (frame_start_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        cs_n;
        logic        vld;
        logic [7:0]  din;
        logic        busy;
        logic        en;
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic [15:0] led;
        logic        fs;
        logic [7:0]  rep;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cs_n, input logic vld, input logic [7:0] din,
                       input logic busy, input logic en, input logic [10:0] addr,
                       input logic [7:0] wdata, input logic [15:0] led,
                       input logic fs, input logic [7:0] rep);
        vec_t v;
        v.cs_n = cs_n; v.vld = vld; v.din = din; v.busy = busy;
        v.en = en; v.addr = addr; v.wdata = wdata; v.led = led;
        v.fs = fs; v.rep = rep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic en, input logic [10:0] addr,
                              input logic [7:0] wdata, input logic [15:0] led,
                              input logic fs, input logic [7:0] rep);
        chk({tag, ".wr_en"},   {31'd0, ram_wr_en_o},   {31'd0, en});
        chk({tag, ".wr_addr"}, {21'd0, ram_wr_addr_o}, {21'd0, addr});
        chk({tag, ".wr_data"}, {24'd0, ram_wr_data_o}, {24'd0, wdata});
        chk({tag, ".led_cnt"}, {16'd0, led_cnt_o},     {16'd0, led});
        chk({tag, ".fstart"},  {31'd0, frame_start_o}, {31'd0, fs});
        chk({tag, ".reply"},   {24'd0, spi_byte_data_o}, {24'd0, rep});
    endtask

    task automatic drive(input logic cs_n, input logic vld, input logic [7:0] din,
                         input logic busy);
        @(negedge clk_i);
        spi_cs_n_i      = cs_n;
        spi_byte_vld_i  = vld;
        spi_byte_data_i = din;
        frame_busy_i    = busy;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset with random inputs toggling.
        rst_n_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            spi_cs_n_i      = 1'($urandom_range(0, 1));
            spi_byte_vld_i  = 1'($urandom_range(0, 1));
            spi_byte_data_i = 8'($urandom_range(0, 255));
            frame_busy_i    = 1'($urandom_range(0, 1));
        end
        #1;
        check_outs("reset", 1'b0, 11'h000, 8'h00, 16'h0000, 1'b0, 8'h00);
        @(negedge clk_i);
        spi_cs_n_i = 1'b1; spi_byte_vld_i = 1'b0; spi_byte_data_i = 8'h00; frame_busy_i = 1'b0;
        rst_n_i = 1'b1;

        //  cs vld din    busy en  addr    wdata  led       fs  rep
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'h00, 16'h0000, 0, 8'h00);
        // Config frame 2A 01 2C
        add(0, 1, 8'h2A, 0,  0, 11'h000, 8'h00, 16'h0000, 0, 8'h00);
        add(0, 1, 8'h01, 0,  0, 11'h000, 8'h00, 16'h0000, 0, 8'h00);
        add(0, 1, 8'h2C, 0,  0, 11'h000, 8'h00, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'h00, 16'h012C, 0, 8'h00);
        // Address frame 2B 07 FE 55 (trailing byte ignored)
        add(0, 1, 8'h2B, 0,  0, 11'h000, 8'h00, 16'h012C, 0, 8'h00);
        add(0, 1, 8'h07, 0,  0, 11'h000, 8'h00, 16'h012C, 0, 8'h00);
        add(0, 1, 8'hFE, 0,  0, 11'h000, 8'h00, 16'h012C, 0, 8'h00);
        add(0, 1, 8'h55, 0,  0, 11'h000, 8'h00, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'h00, 16'h012C, 0, 8'h00);
        // Data frame 2C AA BB CC, wraps 7FF -> 000
        add(0, 1, 8'h2C, 0,  0, 11'h000, 8'h00, 16'h012C, 0, 8'h00);
        add(0, 1, 8'hAA, 0,  1, 11'h7FE, 8'hAA, 16'h012C, 0, 8'h00);
        add(0, 0, 8'h00, 0,  0, 11'h7FE, 8'hAA, 16'h012C, 0, 8'h00);
        add(0, 1, 8'hBB, 0,  1, 11'h7FF, 8'hBB, 16'h012C, 0, 8'h00);
        add(0, 1, 8'hCC, 0,  1, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        // FRAME_GO while busy; pulse the cycle after busy falls
        add(0, 1, 8'h2D, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'hCC, 16'h012C, 1, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        // STATUS_RD busy=1 pending=0 -> 0x01 for one slot
        add(0, 1, 8'h2E, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h01);
        add(0, 1, 8'h00, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(0, 1, 8'h00, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        // Reply holds without a byte, clears on release
        add(0, 1, 8'h2E, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h01);
        add(0, 0, 8'h00, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h01);
        add(1, 0, 8'h00, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        // Status shows pending bit
        add(0, 1, 8'h2D, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(0, 1, 8'h2E, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h03);
        add(1, 0, 8'h00, 1,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'hCC, 16'h012C, 1, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        // FRAME_GO idle: pulse two cycles after the valid
        add(0, 1, 8'h2D, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'hCC, 16'h012C, 1, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        // Mid-argument release keeps led count
        add(0, 1, 8'h2A, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(0, 1, 8'h05, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        // Unknown command sinks the rest
        add(0, 1, 8'hFF, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(0, 1, 8'h2C, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(0, 1, 8'h11, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        // Counter persists across frames
        add(0, 1, 8'h2C, 0,  0, 11'h000, 8'hCC, 16'h012C, 0, 8'h00);
        add(0, 1, 8'h77, 0,  1, 11'h001, 8'h77, 16'h012C, 0, 8'h00);
        // Valid while released is dropped; next byte is a command
        add(1, 1, 8'h55, 0,  0, 11'h001, 8'h77, 16'h012C, 0, 8'h00);
        add(0, 1, 8'h66, 0,  0, 11'h001, 8'h77, 16'h012C, 0, 8'h00);
        add(0, 1, 8'h2C, 0,  0, 11'h001, 8'h77, 16'h012C, 0, 8'h00);
        add(1, 0, 8'h00, 0,  0, 11'h001, 8'h77, 16'h012C, 0, 8'h00);

        foreach (vecs[i]) begin
            drive(vecs[i].cs_n, vecs[i].vld, vecs[i].din, vecs[i].busy);
            check_outs($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].wdata,
                       vecs[i].led, vecs[i].fs, vecs[i].rep);
        end

        // Reset mid DATA frame clears everything immediately.
        drive(0, 1, 8'h2C, 0);
        drive(0, 1, 8'h42, 0);
        check_outs("predrst", 1'b1, 11'h002, 8'h42, 16'h012C, 1'b0, 8'h00);
        @(negedge clk_i);
        spi_byte_vld_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        check_outs("midrst", 1'b0, 11'h000, 8'h00, 16'h0000, 1'b0, 8'h00);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        // First byte after reset is a command; counter restarted at 0.
        drive(0, 1, 8'h2C, 0);
        check_outs("postrst_cmd", 1'b0, 11'h000, 8'h00, 16'h0000, 1'b0, 8'h00);
        drive(0, 1, 8'h9A, 0);
        check_outs("postrst_wr", 1'b1, 11'h000, 8'h9A, 16'h0000, 1'b0, 8'h00);
        drive(1, 0, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer between the SPI byte slave and the LED frame logic. It parses the byte stream received inside each chip-select frame into commands, and drives the pixel RAM write port, the LED-count configuration register and the frame-start request. It also supplies the byte the slave shifts out on MISO for status readback.

## Interface

- ADDR_WIDTH, 11: pixel RAM address width; the address counter wraps modulo 2^ADDR_WIDTH.
- CNT_WIDTH, 16: LED-count register width; must be ≤ 16.

Ports. One clock; reset is asynchronous and active-low.

- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- spi_cs_n_i  in  1  SPI chip select, active low, sampled on clk_i.
- spi_byte_vld_i  in  1  one-cycle pulse: received byte valid.
- spi_byte_data_i  in  8  received byte.
- spi_byte_data_o  out  8  next byte for the slave to transmit.
- frame_busy_i  in  1  LED output engine is refreshing.
- ram_wr_en_o  out  1  pixel RAM write strobe, one cycle.
- ram_wr_addr_o  out  ADDR_WIDTH  pixel RAM write address.
- ram_wr_data_o  out  8  pixel RAM write data.
- led_cnt_o  out  CNT_WIDTH  configured LED count.
- frame_start_o  out  1  one-cycle frame refresh request.

## Operation

- **Command byte.** The first byte after spi_cs_n_i falls is the command. Subsequent bytes are arguments, interpreted according to the command.
  - 0x2A CONF_WR: next 2 bytes, MSB first, form the new LED count, truncated to CNT_WIDTH. led_cnt_o updates after the second byte. Further bytes are ignored.
  - 0x2B ADDR_WR: next 2 bytes, MSB first, set the address counter, truncated to ADDR_WIDTH. The counter loads after the second byte. Further bytes are ignored.
  - 0x2C DATA_WR: every following byte is written to RAM at the counter address, then the counter increments. This continues until chip select is released. The counter value persists across frames.
  - 0x2D FRAME_GO: sets start_pending. While start_pending=1 and frame_busy_i=0, frame_start_o pulses for one cycle and start_pending clears. Further bytes are ignored.
  - 0x2E STATUS_RD: the reply byte becomes {6'h0, start_pending, frame_busy_i}, sampled when the command byte is accepted. It is shifted out during the next byte slot.
  - Any other value: SINK. All bytes are ignored until chip select is released.
- **States.** CMD, CONF_H, CONF_L, ADDR_H, ADDR_L, DATA, SINK.
  - CMD → CONF_H / ADDR_H / DATA on 0x2A / 0x2B / 0x2C.
  - CMD → SINK on any other byte (0x2D and 0x2E act first).
  - CONF_H → CONF_L → SINK.
  - ADDR_H → ADDR_L → SINK.
  - DATA stays in DATA.
  - spi_cs_n_i=1 forces CMD from any state on the next edge.
- **Reply byte.** spi_byte_data_o is 0x00 except during the byte slot immediately following STATUS_RD. It returns to 0x00 on the next accepted byte or on chip-select release.
- **Address wrap.** The counter wraps from 2^ADDR_WIDTH−1 to 0 silently.
- **Simultaneous events.** If spi_byte_vld_i=1 while spi_cs_n_i=1, the byte is dropped.
- **Mid-operation release.** A chip-select release mid-argument (e.g. after CONF_H) discards the partial value. led_cnt_o and the counter stay unchanged.
- **Reset.** Reset mid-operation returns everything to reset values immediately.

## Timing

- **Reset values.** State CMD; addr 0; start_pending 0. All outputs 0: ram_wr_en_o=0, ram_wr_addr_o=0, ram_wr_data_o=0x00, led_cnt_o=0, frame_start_o=0, spi_byte_data_o=0x00.
- **RAM write.** ram_wr_en_o, ram_wr_addr_o and ram_wr_data_o are registered and assert in the cycle after spi_byte_vld_i. The counter increments in the same cycle.
- **Reply latency.** spi_byte_data_o is valid 1 cycle after the command byte's spi_byte_vld_i. This is within the slave's 2-cycle load window.
- **led_cnt_o latency.** Updates 1 cycle after the second argument byte's valid.
- **frame_start_o latency.** Earliest assertion is 2 cycles after the 0x2D valid: pending is set, then the pulse is issued. Otherwise it asserts the cycle after frame_busy_i falls.
- **Throughput.** One byte per cycle is accepted. No back-pressure exists; every valid byte is consumed.

## Structure

- **spi_cmd_pkg.** Holds the command constants CMD_CONF_WR=8'h2A, CMD_ADDR_WR=8'h2B, CMD_DATA_WR=8'h2C, CMD_FRAME_GO=8'h2D, CMD_STATUS_RD=8'h2E, and the state enum typedef.
- **Single module, no sub-modules.** The argument-assembly register (high byte hold) is shared by the CONF and ADDR paths.

## Test plan

- **Reset.** Assert reset with random inputs → all outputs 0, and the first post-reset byte is treated as a command.
- **Config then data.** Frame 0x2A,0x01,0x2C. Then frame 0x2B,0x07,0xFE,0x55 and frame 0x2C,0xAA,0xBB,0xCC → led_cnt_o=0x012C. Writes go to addresses 0x7FE=0xAA, 0x7FF=0xBB, 0x000=0xCC (wrap). The trailing 0x55 produces no write.
- **Start gating.** Frame 0x2D with frame_busy_i=1 → no pulse. Release busy → frame_start_o pulses exactly once, the cycle after busy falls.
- **Status readback.** Frame 0x2E,0x00 with busy=1, pending=0 → second byte slot transmits 0x01. Later slots transmit 0x00.
- **Mid-frame release.** Frame 0x2A,0x05 then release → led_cnt_o unchanged. Next frame 0xFF,0x2C,0x11 → SINK, no RAM write.
- **Simultaneous CS and valid.** spi_byte_vld_i=1 in the same cycle spi_cs_n_i=1 → byte dropped, no write, state CMD.
